// File: rtl/alu_reservation_station.sv
// Reservation station for the integer ALU: buffers renamed instructions, snoops two CDBs
// for operand wakeup and dispatches the lowest-index ready entry each enabled cycle.
module alu_reservation_station #(
  parameter int unsigned RS_BITS  = 3,
  parameter int unsigned ROB_BITS = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear_in,
  input  logic                issue_valid,
  input  logic [5:0]          issue_op,
  input  logic [31:0]         issue_vj,
  input  logic [31:0]         issue_vk,
  input  logic                issue_qj_busy,
  input  logic [ROB_BITS-1:0] issue_qj,
  input  logic                issue_qk_busy,
  input  logic [ROB_BITS-1:0] issue_qk,
  input  logic [ROB_BITS-1:0] issue_dest,
  input  logic                cdb0_valid,
  input  logic [ROB_BITS-1:0] cdb0_tag,
  input  logic [31:0]         cdb0_value,
  input  logic                cdb1_valid,
  input  logic [ROB_BITS-1:0] cdb1_tag,
  input  logic [31:0]         cdb1_value,
  output logic                rs_full,
  output logic [5:0]          alu_op,
  output logic [31:0]         alu_rs1,
  output logic [31:0]         alu_rs2,
  output logic [ROB_BITS-1:0] alu_dest,
  output logic                alu_valid
);
  localparam int unsigned RS_SIZE = 1 << RS_BITS;

  logic [RS_SIZE-1:0]  busy;
  logic [RS_SIZE-1:0]  qj_busy;
  logic [RS_SIZE-1:0]  qk_busy;
  logic [5:0]          op_q   [RS_SIZE];
  logic [31:0]         vj_q   [RS_SIZE];
  logic [31:0]         vk_q   [RS_SIZE];
  logic [ROB_BITS-1:0] qj_q   [RS_SIZE];
  logic [ROB_BITS-1:0] qk_q   [RS_SIZE];
  logic [ROB_BITS-1:0] dest_q [RS_SIZE];

  logic               free_found, ready_found, do_issue;
  logic [RS_BITS-1:0] free_idx, ready_idx;
  logic [31:0]        ins_vj, ins_vk;
  logic               ins_qj_busy, ins_qk_busy;

  assign rs_full  = &busy;
  assign do_issue = issue_valid && (issue_op != '0) && !rs_full;

  // Priority encoders: lowest-index free slot and lowest-index ready entry
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = RS_BITS'(i);
      end
      if (busy[i] && !qj_busy[i] && !qk_busy[i] && !ready_found) begin
        ready_found = 1'b1;
        ready_idx   = RS_BITS'(i);
      end
    end
  end

  // Same-cycle CDB forwarding for the incoming instruction; cdb0 wins on a tie
  always_comb begin
    ins_vj      = issue_vj;
    ins_qj_busy = issue_qj_busy;
    ins_vk      = issue_vk;
    ins_qk_busy = issue_qk_busy;
    if (issue_qj_busy) begin
      if (cdb0_valid && cdb0_tag == issue_qj) begin
        ins_vj      = cdb0_value;
        ins_qj_busy = 1'b0;
      end else if (cdb1_valid && cdb1_tag == issue_qj) begin
        ins_vj      = cdb1_value;
        ins_qj_busy = 1'b0;
      end
    end
    if (issue_qk_busy) begin
      if (cdb0_valid && cdb0_tag == issue_qk) begin
        ins_vk      = cdb0_value;
        ins_qk_busy = 1'b0;
      end else if (cdb1_valid && cdb1_tag == issue_qk) begin
        ins_vk      = cdb1_value;
        ins_qk_busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      busy      <= '0;
      alu_op    <= '0;
      alu_rs1   <= '0;
      alu_rs2   <= '0;
      alu_dest  <= '0;
      alu_valid <= 1'b0;
    end else if (rdy_in) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && qj_busy[i]) begin
          if (cdb0_valid && cdb0_tag == qj_q[i]) begin
            vj_q[i]    <= cdb0_value;
            qj_busy[i] <= 1'b0;
          end else if (cdb1_valid && cdb1_tag == qj_q[i]) begin
            vj_q[i]    <= cdb1_value;
            qj_busy[i] <= 1'b0;
          end
        end
        if (busy[i] && qk_busy[i]) begin
          if (cdb0_valid && cdb0_tag == qk_q[i]) begin
            vk_q[i]    <= cdb0_value;
            qk_busy[i] <= 1'b0;
          end else if (cdb1_valid && cdb1_tag == qk_q[i]) begin
            vk_q[i]    <= cdb1_value;
            qk_busy[i] <= 1'b0;
          end
        end
      end

      if (ready_found) begin
        alu_op          <= op_q[ready_idx];
        alu_rs1         <= vj_q[ready_idx];
        alu_rs2         <= vk_q[ready_idx];
        alu_dest        <= dest_q[ready_idx];
        alu_valid       <= 1'b1;
        busy[ready_idx] <= 1'b0;
      end else begin
        alu_op    <= '0;
        alu_rs1   <= '0;
        alu_rs2   <= '0;
        alu_dest  <= '0;
        alu_valid <= 1'b0;
      end

      // The free slot is never busy, so it cannot collide with wakeup or dispatch
      if (do_issue) begin
        busy[free_idx]    <= 1'b1;
        op_q[free_idx]    <= issue_op;
        vj_q[free_idx]    <= ins_vj;
        vk_q[free_idx]    <= ins_vk;
        qj_busy[free_idx] <= ins_qj_busy;
        qk_busy[free_idx] <= ins_qk_busy;
        qj_q[free_idx]    <= issue_qj;
        qk_q[free_idx]    <= issue_qk;
        dest_q[free_idx]  <= issue_dest;
      end
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed self-checking bench for alu_reservation_station.
module tb_alu_reservation_station;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic        issue_valid, issue_qj_busy, issue_qk_busy;
  logic [5:0]  issue_op;
  logic [31:0] issue_vj, issue_vk;
  logic [3:0]  issue_qj, issue_qk, issue_dest;
  logic        cdb0_valid, cdb1_valid;
  logic [3:0]  cdb0_tag, cdb1_tag;
  logic [31:0] cdb0_value, cdb1_value;
  logic        rs_full, alu_valid;
  logic [5:0]  alu_op;
  logic [31:0] alu_rs1, alu_rs2;
  logic [3:0]  alu_dest;
  logic [74:0] outv;
  logic [74:0] exp_v;

  localparam logic [5:0] OP_ADD = 6'd1, OP_SUB = 6'd2, OP_AND = 6'd3, OP_OR = 6'd4, OP_XOR = 6'd5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;
  assign outv = {alu_valid, alu_op, alu_rs1, alu_rs2, alu_dest};

  alu_reservation_station #(.RS_BITS(3), .ROB_BITS(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj), .issue_qk_busy(issue_qk_busy),
    .issue_qk(issue_qk), .issue_dest(issue_dest),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_value(cdb0_value),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value),
    .rs_full(rs_full), .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_dest(alu_dest), .alu_valid(alu_valid)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_op = '0; issue_vj = '0; issue_vk = '0;
    issue_qj_busy = 1'b0; issue_qj = '0; issue_qk_busy = 1'b0; issue_qk = '0; issue_dest = '0;
    cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_value = '0;
    cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_value = '0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic qjb, input logic [3:0] qj, input logic qkb,
                       input logic [3:0] qk, input logic [3:0] dest);
    issue_valid = 1'b1; issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_qj_busy = qjb; issue_qj = qj; issue_qk_busy = qkb; issue_qk = qk; issue_dest = dest;
  endtask

  task automatic cdb0(input logic [3:0] tag, input logic [31:0] val);
    cdb0_valid = 1'b1; cdb0_tag = tag; cdb0_value = val;
  endtask

  task automatic cdb1(input logic [3:0] tag, input logic [31:0] val);
    cdb1_valid = 1'b1; cdb1_tag = tag; cdb1_value = val;
  endtask

  task automatic test_reset();
    idle();
    clear_in = 1'b0;
    rdy_in = 1'b0;
    rst_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0;
    n_checks++;
    if (outv !== 75'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outv); end
    n_checks++;
    if (rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", rs_full); end
    rdy_in = 1'b1;
  endtask

  task automatic test_basic();
    issue(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    tick(); idle();
    n_checks++;
    if (outv !== 75'd0) begin n_fail++; $display("FAIL basic_early: got %h expected 0", outv); end
    tick();
    exp_v = {1'b1, OP_ADD, 32'd5, 32'd7, 4'd3};
    n_checks++;
    if (outv !== exp_v) begin n_fail++; $display("FAIL basic_dispatch: got %h expected %h", outv, exp_v); end
    tick();
    n_checks++;
    if (outv !== 75'd0) begin n_fail++; $display("FAIL basic_idle: got %h expected 0", outv); end
    issue(6'd0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
    tick(); idle(); tick();
    n_checks++;
    if (outv !== 75'd0) begin n_fail++; $display("FAIL op_zero_ignored: got %h expected 0", outv); end
  endtask

  task automatic test_wakeup();
    issue(OP_SUB, 32'd0, 32'd3, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4);
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (outv !== 75'd0) begin n_fail++; $display("FAIL wake_wait%0d: got %h expected 0", i, outv); end
      if (i < 3) tick();
    end
    cdb1(4'd2, 32'h10);
    tick(); idle();
    n_checks++;
    if (outv !== 75'd0) begin n_fail++; $display("FAIL wake_edge: got %h expected 0", outv); end
    tick();
    exp_v = {1'b1, OP_SUB, 32'h10, 32'd3, 4'd4};
    n_checks++;
    if (outv !== exp_v) begin n_fail++; $display("FAIL wake_dispatch: got %h expected %h", outv, exp_v); end
    issue(OP_AND, 32'd0, 32'd9, 1'b1, 4'd5, 1'b0, 4'd0, 4'd6);
    tick(); idle();
    cdb0(4'd5, 32'hA); cdb1(4'd5, 32'hB);
    tick(); idle(); tick();
    exp_v = {1'b1, OP_AND, 32'hA, 32'd9, 4'd6};
    n_checks++;
    if (outv !== exp_v) begin n_fail++; $display("FAIL cdb_priority: got %h expected %h", outv, exp_v); end
    tick();
  endtask

  task automatic test_forward();
    issue(OP_XOR, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd2);
    cdb0(4'd6, 32'hFFFF_FFFF);
    tick(); idle();
    n_checks++;
    if (outv !== 75'd0) begin n_fail++; $display("FAIL fwd_early: got %h expected 0", outv); end
    tick();
    exp_v = {1'b1, OP_XOR, 32'd1, 32'hFFFF_FFFF, 4'd2};
    n_checks++;
    if (outv !== exp_v) begin n_fail++; $display("FAIL fwd_dispatch: got %h expected %h", outv, exp_v); end
    tick();
  endtask

  task automatic test_full();
    for (int k = 0; k < 8; k++) begin
      issue(OP_OR, 32'd0, 32'(k), 1'b1, 4'd9, 1'b0, 4'd0, 4'(k));
      tick();
    end
    idle();
    n_checks++;
    if (rs_full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %b expected 1", rs_full); end
    issue(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    tick(); idle();
    n_checks++;
    if (rs_full !== 1'b1) begin n_fail++; $display("FAIL full_hold: got %b expected 1", rs_full); end
    cdb0(4'd9, 32'h99);
    tick(); idle();
    n_checks++;
    if (outv !== 75'd0) begin n_fail++; $display("FAIL full_wake_edge: got %h expected 0", outv); end
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_v = {1'b1, OP_OR, 32'h99, 32'(k), 4'(k)};
      n_checks++;
      if (outv !== exp_v) begin n_fail++; $display("FAIL full_order%0d: got %h expected %h", k, outv, exp_v); end
      if (k == 0) begin
        n_checks++;
        if (rs_full !== 1'b0) begin n_fail++; $display("FAIL full_drop: got %b expected 0", rs_full); end
      end
    end
    tick();
    n_checks++;
    if (outv !== 75'd0) begin n_fail++; $display("FAIL full_ninth_dropped: got %h expected 0", outv); end
  endtask

  task automatic test_priority();
    issue(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd7,  1'b0, 4'd0, 4'd0); tick();
    issue(OP_ADD, 32'd0, 32'd1, 1'b1, 4'd10, 1'b0, 4'd0, 4'd1); tick();
    issue(OP_ADD, 32'd0, 32'd2, 1'b1, 4'd8,  1'b0, 4'd0, 4'd2); tick();
    issue(OP_ADD, 32'd0, 32'd3, 1'b1, 4'd8,  1'b0, 4'd0, 4'd3); tick();
    issue(OP_ADD, 32'd0, 32'd4, 1'b1, 4'd10, 1'b0, 4'd0, 4'd4); tick();
    idle();
    cdb1(4'd10, 32'h50);
    tick(); idle(); tick();
    exp_v = {1'b1, OP_ADD, 32'h50, 32'd1, 4'd1};
    n_checks++;
    if (outv !== exp_v) begin n_fail++; $display("FAIL prio_first: got %h expected %h", outv, exp_v); end
    tick();
    exp_v = {1'b1, OP_ADD, 32'h50, 32'd4, 4'd4};
    n_checks++;
    if (outv !== exp_v) begin n_fail++; $display("FAIL prio_second: got %h expected %h", outv, exp_v); end
    tick();
    n_checks++;
    if (outv !== 75'd0) begin n_fail++; $display("FAIL prio_gap: got %h expected 0", outv); end
    cdb0(4'd7, 32'h70);
    tick(); idle(); tick();
    exp_v = {1'b1, OP_ADD, 32'h70, 32'd0, 4'd0};
    n_checks++;
    if (outv !== exp_v) begin n_fail++; $display("FAIL prio_entry0: got %h expected %h", outv, exp_v); end
    cdb1(4'd8, 32'h80);
    tick(); idle(); tick();
    exp_v = {1'b1, OP_ADD, 32'h80, 32'd2, 4'd2};
    n_checks++;
    if (outv !== exp_v) begin n_fail++; $display("FAIL prio_entry2: got %h expected %h", outv, exp_v); end
    tick();
    exp_v = {1'b1, OP_ADD, 32'h80, 32'd3, 4'd3};
    n_checks++;
    if (outv !== exp_v) begin n_fail++; $display("FAIL prio_entry3: got %h expected %h", outv, exp_v); end
    tick();
  endtask

  task automatic test_back_to_back();
    issue(OP_ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1); tick();
    issue(OP_SUB, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2); tick();
    exp_v = {1'b1, OP_ADD, 32'd1, 32'd2, 4'd1};
    n_checks++;
    if (outv !== exp_v) begin n_fail++; $display("FAIL b2b_a: got %h expected %h", outv, exp_v); end
    issue(OP_XOR, 32'd5, 32'd6, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3); tick();
    exp_v = {1'b1, OP_SUB, 32'd3, 32'd4, 4'd2};
    n_checks++;
    if (outv !== exp_v) begin n_fail++; $display("FAIL b2b_b: got %h expected %h", outv, exp_v); end
    idle(); tick();
    exp_v = {1'b1, OP_XOR, 32'd5, 32'd6, 4'd3};
    n_checks++;
    if (outv !== exp_v) begin n_fail++; $display("FAIL b2b_c: got %h expected %h", outv, exp_v); end
    tick();
  endtask

  task automatic test_clear();
    for (int k = 0; k < 4; k++) begin
      issue(OP_OR, 32'd0, 32'd0, 1'b1, 4'd11, 1'b0, 4'd0, 4'(k));
      tick();
    end
    issue(OP_ADD, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4); tick();
    idle();
    clear_in = 1'b1;
    issue(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
    cdb0(4'd11, 32'd1);
    tick();
    clear_in = 1'b0; idle();
    n_checks++;
    if (outv !== 75'd0) begin n_fail++; $display("FAIL clear_outputs: got %h expected 0", outv); end
    n_checks++;
    if (rs_full !== 1'b0) begin n_fail++; $display("FAIL clear_full: got %b expected 0", rs_full); end
    cdb0(4'd11, 32'd5);
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL clear_flushed%0d: got %b expected 0", i, alu_valid); end
      tick();
    end
  endtask

  task automatic test_rdy();
    issue(OP_AND, 32'h21, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7); tick();
    issue(OP_OR,  32'h31, 32'h32, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8); tick();
    exp_v = {1'b1, OP_AND, 32'h21, 32'h22, 4'd7};
    n_checks++;
    if (outv !== exp_v) begin n_fail++; $display("FAIL rdy_first: got %h expected %h", outv, exp_v); end
    rdy_in = 1'b0;
    issue(OP_XOR, 32'h41, 32'h42, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (outv !== exp_v) begin n_fail++; $display("FAIL rdy_hold%0d: got %h expected %h", i, outv, exp_v); end
    end
    rdy_in = 1'b1; idle(); tick();
    exp_v = {1'b1, OP_OR, 32'h31, 32'h32, 4'd8};
    n_checks++;
    if (outv !== exp_v) begin n_fail++; $display("FAIL rdy_resume: got %h expected %h", outv, exp_v); end
    tick();
    n_checks++;
    if (outv !== 75'd0) begin n_fail++; $display("FAIL rdy_issue_ignored: got %h expected 0", outv); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_forward();
    test_full();
    test_priority();
    test_back_to_back();
    test_clear();
    test_rdy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station for the integer ALU in the out-of-order core.
- Buffers decoded ALU and branch instructions from the dispatcher until both source operands are available.
- Snoops two common data buses (CDBs) for operand wakeup.
- Issues at most one ready instruction per cycle as registered rs1/rs2/op/dest to the combinational ALU, which treats op==0 as idle.

Parameters:
RS_BITS, 3, log2 of entry count (RS_SIZE = 2^RS_BITS = 8)
ROB_BITS, 4, width of ROB tags used for renaming and result destination

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global clock enable; low = hold all state, outputs unchanged
clear_in  input  1  pipeline flush (mispredict); synchronous, same effect as reset
issue_valid  input  1  dispatcher presents an instruction this cycle
issue_op  input  6  ALU opcode (0 = none; ignored)
issue_vj  input  32  operand 1 value (valid when issue_qj_busy=0)
issue_vk  input  32  operand 2 value/immediate/pc (valid when issue_qk_busy=0)
issue_qj_busy  input  1  operand 1 still pending
issue_qj  input  ROB_BITS  producer tag of operand 1
issue_qk_busy  input  1  operand 2 still pending
issue_qk  input  ROB_BITS  producer tag of operand 2
issue_dest  input  ROB_BITS  ROB entry receiving the result
cdb0_valid  input  1  ALU result broadcast
cdb0_tag  input  ROB_BITS  ALU broadcast tag
cdb0_value  input  32  ALU broadcast value
cdb1_valid  input  1  load/store buffer broadcast
cdb1_tag  input  ROB_BITS  LSB broadcast tag
cdb1_value  input  32  LSB broadcast value
rs_full  output  1  all entries occupied
alu_op  output  6  opcode to ALU (0 when idle)
alu_rs1  output  32  operand 1 to ALU
alu_rs2  output  32  operand 2 to ALU
alu_dest  output  ROB_BITS  ROB tag accompanying the ALU result
alu_valid  output  1  one-cycle strobe: alu_* outputs carry a dispatched instruction

Behaviour:
- Entry state: busy, op, vj, vk, qj_busy, qj, qk_busy, qk, dest.
- Reset / clear_in (evaluated at edge, independent of rdy_in):
  - All busy=0.
  - alu_op=0, alu_rs1=0, alu_rs2=0, alu_dest=0, alu_valid=0.
  - rs_full=0 at the next cycle.
  - clear_in overrides issue, wakeup and dispatch in the same cycle.
- rdy_in=0: no state change; outputs hold.
- rs_full: combinational from registered busy bits; 1 iff all RS_SIZE entries are busy.
- Issue:
  - On issue_valid=1, issue_op!=0 and rs_full=0, write the lowest-index non-busy entry.
  - issue_valid while rs_full=1 is dropped; the dispatcher must not do this.
  - Same-cycle forwarding: if issue_qj_busy and a CDB is valid with tag==issue_qj, store that value with qj_busy=0. Same rule for qk.
- Wakeup:
  - Every busy entry with qj_busy and a matching valid CDB tag captures the value and clears qj_busy. Same for qk.
  - cdb0 has priority if both CDBs match one tag.
- Dispatch:
  - Each enabled cycle, select the lowest-index busy entry with qj_busy=0 and qk_busy=0, using registered state at the start of the cycle.
  - At the edge, drive alu_op/rs1/rs2/dest from that entry, set alu_valid=1, and free the entry (busy=0).
  - If no entry is ready: alu_valid=0 and alu_op=0. rs1/rs2/dest are don't-care; drive 0.
- Latency:
  - Instruction issued with both operands ready at edge N appears on alu_* after edge N+1.
  - Entry woken by a CDB at edge N dispatches at edge N+1 at earliest.
  - Forwarded-at-issue entries follow the same N+1 rule.
- Issue and dispatch in the same cycle are independent. A freed slot is reusable from the following cycle, since rs_full is computed from pre-edge state.
- Throughput: 1 dispatch/cycle; 1 issue/cycle while not full.

Test Plan:
- Reset then issue Add (vj=5, vk=7, dest=3, both ready) -> one cycle later alu_valid=1, alu_op=Add, alu_rs1=5, alu_rs2=7, alu_dest=3; following cycle alu_valid=0, alu_op=0.
- Issue Sub with qj_busy=1, qj=2; hold 3 cycles with no alu_valid; cdb1 tag=2 value=0x10 -> dispatch next cycle with alu_rs1=0x10.
- Issue with qk=6 pending while cdb0_valid tag=6 value=0xFFFFFFFF in the same cycle -> dispatched next cycle with alu_rs2=0xFFFFFFFF.
- Fill 8 entries, all pending on tag 9 -> rs_full=1; 9th issue ignored; cdb0 tag 9 -> entries dispatch in index order 0..7 on consecutive cycles; rs_full drops after the first dispatch.
- Entries 1 and 4 ready, entry 0 pending -> entry 1 dispatches first, then entry 4; entry 0 dispatches only after its wakeup.
- clear_in asserted with 5 busy entries and a concurrent issue -> next cycle rs_full=0, alu_valid=0, and no later dispatch of any flushed entry; rdy_in=0 for 2 cycles with a ready entry -> no dispatch until rdy_in returns.
